uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte on the receiver's one-cycle done pulse, so received data survives until software or the host logic reads it. Reads are first-word-fall-through: the oldest byte is always presented on dout, and a read strobe pops it. The block also reports fill level, almost-full and a sticky overrun flag for flow-control and error handling.

Parameters:
DATA_WIDTH, 8, width of each stored word (one UART character)
ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH = 16 entries
AF_LEVEL, 12, count at or above which almost_full asserts; legal range 1..2**ADDR_WIDTH

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
wr  input  1  write strobe; connects to the receiver done pulse; one write per cycle high
din  input  DATA_WIDTH  write data; sampled only in cycles where wr=1
rd  input  1  read/pop strobe; one pop per cycle high
dout  output  DATA_WIDTH  oldest stored word (FWFT); all zeros when empty=1
empty  output  1  1 when count==0
full  output  1  1 when count==2**ADDR_WIDTH
count  output  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH
almost_full  output  1  1 when count>=AF_LEVEL
overrun  output  1  sticky; set when a write is dropped because the FIFO is full
clr_overrun  input  1  clears overrun on the next edge

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, almost_full=0, overrun=0, dout=0. Storage array contents are not reset.
- Storage and pointers:
  - Storage is a 2**ADDR_WIDTH x DATA_WIDTH register array.
  - Both pointers are ADDR_WIDTH bits and wrap naturally from 2**ADDR_WIDTH-1 to 0.
- Status flags: all flags are registered, or derived combinationally from the registered count; there is no combinational path from rd/wr to any flag.
- Effective operations each cycle:
  - do_wr = wr & (~full | rd)
  - do_rd = rd & ~empty
- Write: on do_wr, mem[wr_ptr]<=din and wr_ptr<=wr_ptr+1.
- Read: on do_rd, rd_ptr<=rd_ptr+1.
- Read latency:
  - dout = mem[rd_ptr], gated to 0 when empty.
  - A word written in cycle N appears on dout from cycle N+1 if the FIFO was empty.
  - rd in the same cycle as that write is ignored, because empty=1.
- Count update:
  - +1 on do_wr & ~do_rd
  - -1 on do_rd & ~do_wr
  - unchanged otherwise
- Boundary conditions:
  - Empty with rd=1, wr=0: no change, no error flag (underflow is silently ignored).
  - Empty with rd=1, wr=1: write occurs, read ignored, count becomes 1.
  - Full with wr=1, rd=0: write dropped, pointers unchanged, overrun<=1.
  - Full with wr=1, rd=1: pop and push both occur, count stays at 2**ADDR_WIDTH, overrun unchanged.
  - Pointer wrap: ordering is preserved across the wrap; full and empty are distinguished by count, not by pointer equality.
- overrun:
  - Set has priority over clear: if a dropped write and clr_overrun occur in the same cycle, overrun=1 next cycle.
  - Otherwise clr_overrun=1 drives overrun to 0.
- Reset mid-operation: all stored data is discarded (count=0, empty=1) on the next edge, regardless of wr/rd/clr_overrun in that cycle.
- Arithmetic: count is ADDR_WIDTH+1 bits with no wrap.
- Parameter guard: AF_LEVEL outside 1..2**ADDR_WIDTH is a configuration error and is flagged by a simulation-time check.

Test Plan:
- Reset, then write 0x41, 0x42, 0x43 on separate cycles -> dout=0x41 the cycle after the first write; three pops give 0x41, 0x42, 0x43; count goes 3→0; empty=1 at end.
- Write 16 bytes 0x00..0x0F -> full=1, count=16; almost_full asserted from the 12th write; 17th write 0xAA dropped, overrun=1; popping returns 0x00..0x0F, never 0xAA.
- Full FIFO, wr=1 and rd=1 together with din=0x55 -> dout advances to the next word, count stays 16, overrun stays 0; 0x55 emerges after 15 further pops.
- Empty FIFO, wr=1 din=0x7E with rd=1 the same cycle -> count=1, dout=0x7E next cycle; rd with count=0 and wr=0 -> count stays 0, no flag.
- Pointer wrap: 20 cycles of alternating write/pop of an incrementing pattern across index 15→0 -> output sequence matches input exactly; count never exceeds 1.
- overrun=1, then clr_overrun=1 in the same cycle as a full-FIFO dropped write -> overrun remains 1; clr_overrun alone next cycle -> overrun=0. reset asserted with count=9 -> next cycle count=0, empty=1, dout=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// First-word-fall-through: dout always shows the oldest stored byte.
// Strobe semantics: wr and rd are single-cycle strobes and there is no
// back-pressure handshake. A write is accepted when wr=1 and the FIFO is
// not full, or when it is full but a pop happens in the same cycle. A
// write that is not accepted is dropped and sets overrun. A read is
// accepted when rd=1 and the FIFO is not empty. A read on an empty FIFO
// is ignored and raises no flag.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overrun;

    logic w_empty;
    logic w_full;
    logic w_do_wr;
    logic w_do_rd;
    logic w_drop;

    // Flags come only from the registered count, never from rd/wr.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A full FIFO still accepts a write when a pop frees a slot this cycle.
    assign w_do_wr = wr & (~w_full | rd);
    assign w_do_rd = rd & ~w_empty;
    assign w_drop  = wr & w_full & ~rd;

    assign empty       = w_empty;
    assign full        = w_full;
    assign count       = r_count;
    assign almost_full = (r_count >= AF_C);
    assign overrun     = r_overrun;
    assign dout        = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written on accepted writes, contents not reset.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; full and empty are told apart by count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun: a dropped write wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Configuration guard: the almost-full threshold must lie in 1..DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            af_level_legal: assert (AF_LEVEL >= 1 && AF_LEVEL <= DEPTH)
                else $error("uart_rx_fifo: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based model of the FIFO, directed scenario
// tasks and a randomized run, all compared against the model.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       almost_full;
    logic       overrun;
    logic       clr_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected contents, oldest first, plus expected overrun.
    logic [7:0] exp_q[$];
    logic       exp_ovr;

    uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(12)) dut (
        .clk(clk), .reset(reset), .wr(wr), .din(din), .rd(rd), .dout(dout),
        .empty(empty), .full(full), .count(count), .almost_full(almost_full),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_dout();
        return (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    endfunction

    // Driver: apply one cycle of inputs, advance the model at the edge,
    // return 1 time unit after the edge so outputs can be sampled.
    task automatic drive(input logic w, input logic [7:0] d, input logic r,
                         input logic c, input logic rst);
        bit m_full;
        bit m_empty;
        bit m_wr;
        bit m_rd;
        @(negedge clk);
        wr = w; din = d; rd = r; clr_overrun = c; reset = rst;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_ovr = 1'b0;
        end else begin
            m_full  = (exp_q.size() == 16);
            m_empty = (exp_q.size() == 0);
            m_wr    = w && (!m_full || r);
            m_rd    = r && !m_empty;
            if (m_rd) void'(exp_q.pop_front());
            if (m_wr) exp_q.push_back(d);
            if (w && m_full && !r) exp_ovr = 1'b1;
            else if (c)            exp_ovr = 1'b0;
        end
        #1;
        wr = 1'b0; rd = 1'b0; clr_overrun = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({count, empty, full, almost_full, overrun, dout} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b af=%b ovr=%b dout=%h, required 0 1 0 0 0 00",
                     count, empty, full, almost_full, overrun, dout);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        vals[0] = 8'h41; vals[1] = 8'h42; vals[2] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (dout !== 8'h41 || count !== 5'(i + 1) || empty !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_write%0d: dout=%h count=%0d empty=%b, required 41 %0d 0", i, dout, count, empty, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dout !== vals[i] || count !== 5'(3 - i)) begin
                n_fail++;
                $display("FAIL basic_pop%0d: dout=%h count=%0d, required %h %0d", i, dout, count, vals[i], 3 - i);
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_drained: count=%0d empty=%b dout=%h, required 0 1 00", count, empty, dout);
        end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (count !== 5'(i + 1) || almost_full !== (i >= 11) || full !== (i == 15)) begin
                n_fail++;
                $display("FAIL fill_write%0d: count=%0d af=%b full=%b, required %0d %b %b",
                         i, count, almost_full, full, i + 1, (i >= 11), (i == 15));
            end
        end
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 1'b1 || count !== 5'd16 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL fill_drop: ovr=%b count=%0d dout=%h, required 1 16 00", overrun, count, dout);
        end
        // Clear overrun while still full, ready for the simultaneous case.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_clr: ovr=%b, required 0", overrun);
        end
    endtask

    task automatic test_full_rdwr();
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dout !== 8'h01 || count !== 5'd16 || overrun !== 1'b0 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_rdwr: dout=%h count=%0d ovr=%b full=%b, required 01 16 0 1", dout, count, overrun, full);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (dout !== ((i < 15) ? 8'(i + 1) : 8'h55) || dout !== exp_dout()) begin
                n_fail++;
                $display("FAIL full_pop%0d: dout=%h, required %h", i, dout, (i < 15) ? 8'(i + 1) : 8'h55);
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL full_drained: empty=%b count=%0d, required 1 0", empty, count);
        end
    endtask

    task automatic test_empty_rdwr();
        drive(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd1 || dout !== 8'h7E || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rdwr: count=%0d dout=%h empty=%b, required 1 7e 0", count, dout, empty);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL underflow: count=%0d empty=%b ovr=%b dout=%h, required 0 1 0 00", count, empty, overrun, dout);
        end
    endtask

    task automatic test_wrap();
        // Start from pointer 0 so twenty write/pop pairs cross index 15->0.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (dout !== 8'(8'hC0 + i) || count !== 5'd1) begin
                n_fail++;
                $display("FAIL wrap_write%0d: dout=%h count=%0d, required %h 1", i, dout, count, 8'(8'hC0 + i));
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (count !== 5'd0) begin
                n_fail++;
                $display("FAIL wrap_pop%0d: count=%0d, required 0", i, count);
            end
        end
    endtask

    task automatic test_overrun_clr_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_priority: ovr=%b, required 1", overrun);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: ovr=%b, required 0", overrun);
        end
        for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd9 || dout !== exp_dout()) begin
            n_fail++;
            $display("FAIL pre_reset: count=%0d dout=%h, required 9 %h", count, dout, exp_dout());
        end
        drive(1'b1, 8'h12, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d empty=%b dout=%h ovr=%b, required 0 1 00 0", count, empty, dout, overrun);
        end
    endtask

    task automatic test_random();
        logic w, r, c;
        int   phase;
        for (int i = 0; i < 600; i++) begin
            // Alternate fill-biased and drain-biased phases to reach both ends.
            phase = (i / 60) % 2;
            w = ($urandom_range(0, 99) < ((phase == 0) ? 75 : 30));
            r = ($urandom_range(0, 99) < ((phase == 0) ? 30 : 75));
            c = ($urandom_range(0, 99) < 10);
            drive(w, 8'($urandom_range(0, 255)), r, c, 1'b0);
            n_checks++;
            if ({dout, count, empty, full, almost_full, overrun} !==
                {exp_dout(), 5'(exp_q.size()), exp_q.size() == 0, exp_q.size() == 16, exp_q.size() >= 12, exp_ovr}) begin
                n_fail++;
                $display("FAIL random%0d: dout=%h count=%0d e=%b f=%b af=%b ovr=%b, required %h %0d %b %b %b %b",
                         i, dout, count, empty, full, almost_full, overrun, exp_dout(), exp_q.size(),
                         exp_q.size() == 0, exp_q.size() == 16, exp_q.size() >= 12, exp_ovr);
            end
        end
    endtask

    initial begin
        wr = 1'b0; din = 8'h00; rd = 1'b0; clr_overrun = 1'b0; reset = 1'b1;
        exp_ovr = 1'b0;
        test_reset();
        test_basic();
        test_fill_overrun();
        test_full_rdwr();
        test_empty_rdwr();
        test_wrap();
        test_overrun_clr_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
